data_path: RTL and testbench
============================

# data_path

Datapath stage directly downstream of the mode/timer control FSM. It holds the step register `s` and the value register `y`, and executes the per-cycle micro-operations the FSM issues: preset, add/subtract by step, increment/decrement, load from `x`, and clear. It returns `y_inc` to the FSM, the wrap-ahead flag that tells the FSM to bump `y` during counting, and drives status flags for the display/top level.

## Interface
- `SW`, 3: width of `s`.
- `YW`, 8: width of `y` and `x`.
- `S_MOD`, 3: modulus of `s` in add mode. Must satisfy 2 ≤ S_MOD ≤ 2^SW.
- `S_INIT`, 6: preset value loaded into `s` by `s_zero`. Must be < 2^SW.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `x`  in  YW  external value, loaded into `y` by `y_store_x`.
- `s_en`  in  1  enables the `s` update this cycle.
- `s_zero`  in  1  when 1, `s` loads `S_INIT`.
- `s_add`  in  1  selects the arithmetic direction when `s_zero`=0: 1 = add, 0 = subtract.
- `s_step`  in  2  step amount, 0..3.
- `y_en`  in  1  enables the `y` update this cycle.
- `y_store_x`  in  1  when 1, `y` loads `x`.
- `y_select_next`  in  2  `y` operation when `y_store_x`=0.
- `s`  out  SW  step register.
- `y`  out  YW  value register.
- `y_inc`  out  1  combinational: 1 iff `s` == S_MOD−1.
- `s_empty`  out  1  combinational: 1 iff `s` == 0.
- `y_ovf`  out  1  sticky flag: 1 after `y` wraps up or down.

## Operation
- `s` update on a clock edge with `s_en`=1, priority top-down:
  - `s_zero`=1: `s` ← S_INIT. `s_add` and `s_step` are ignored.
  - `s_add`=1: compute sum = `s` + `s_step` in SW+1 bits.
    - If sum ≥ S_MOD: `s` ← sum − S_MOD. Only a single subtraction is applied; the result is truncated to SW bits.
    - Otherwise: `s` ← sum.
  - `s_add`=0: `s` ← max(`s` − `s_step`, 0). This saturates at 0 and never wraps.
- `s_en`=0: `s` holds, regardless of the other `s_*` inputs.
- `y` update on a clock edge with `y_en`=1:
  - `y_store_x`=1: `y` ← `x`, and `y_ovf` ← 0. The load has priority over `y_select_next`.
  - `y_select_next`=0: hold.
  - `y_select_next`=1: `y` ← `y`+1 mod 2^YW. If `y` was all-ones, `y_ovf` ← 1.
  - `y_select_next`=2: `y` ← `y`−1 mod 2^YW. If `y` was 0, `y_ovf` ← 1.
  - `y_select_next`=3: `y` ← 0. `y_ovf` is unchanged.
- `y_en`=0: `y` and `y_ovf` hold.
- The `s` and `y` paths are independent. Simultaneous updates both apply on the same edge.
- `y_inc` and `s_empty` derive from the current registered `s` only, never from the inputs. This means the FSM sees the flags for the value `s` holds before the edge.

## Timing
- Reset values: `s`=0, `y`=0, `y_ovf`=0. Consequently `s_empty`=1 and `y_inc`=(S_MOD==1 ? 1 : 0), which is 0 with the defaults.
- `rst` takes effect immediately, without waiting for a clock edge, and dominates all enables. If asserted mid-operation, any in-flight update is discarded. The first update after release occurs on the first rising edge with `rst` low.
- Latency: one cycle from the enables being sampled to the new `s`/`y` being visible. The flags follow combinationally in the same cycle as the new `s`.
- There is no handshake. All controls are level-sampled every edge, and the FSM holding an enable high repeats the operation every cycle by design (e.g. countdown 6→4→2→0→0).
- `s_step`=0 with `s_en`=1 is legal and leaves `s` unchanged.
- Inputs must be stable around the rising edge of `clk`. There are no internal synchronizers.

## Test plan
- **Async reset mid-operation:** drive `s`=5, `y`=0x09, then pulse `rst` between clock edges. Required: `s`=0, `y`=0, `y_ovf`=0, `s_empty`=1 before the next edge.
- **Preset/countdown:**
  - `s_en`=1, `s_zero`=1 → `s`=6.
  - Then `s_zero`=0, `s_add`=0, `s_step`=2 for 4 edges → 4, 2, 0, 0. `s_empty`=1 from the third edge.
- **Count wrap (S_MOD=3):**
  - From `s`=0, with `s_add`=1 and `s_step`=1, over 4 edges → 1, 2, 0, 1.
  - `y_inc`=1 exactly while `s`=2.
  - From `s`=6 with add step 1 → `s`=4 (7−3).
- **Y ops:**
  - `y_store_x`=1 with `x`=0x5A → `y`=0x5A, `y_ovf`=0.
  - `y`=0xFF with select=1 → `y`=0x00, `y_ovf`=1.
  - Select=3 → `y`=0, `y_ovf` stays 1.
  - Select=2 from 0 → `y`=0xFF.
- **Saturation and hold:**
  - `s`=2, subtract step 3 → `s`=0.
  - `s_en`=0 with `s_zero`=1 → `s` unchanged.
  - `y_en`=0 with `y_store_x`=1 → `y` unchanged.
- **Simultaneous:** `s_en`=1 (add 1, `s`=2) and `y_en`=1 (select=1, `y`=4) on the same edge → `s`=0, `y`=5 after that single edge.

Source files
------------

// File: rtl/data_path.sv
// ---------------------------------------------------------------------------
// data_path
//   Datapath stage that sits directly below the mode/timer control FSM. It
//   holds the step register s and the value register y, and executes the
//   micro-operations the FSM issues each cycle.
//
//   s path: preset to S_INIT, modular add (modulus S_MOD) or saturating
//           subtract by s_step, or hold.
//   y path: load from x, hold, increment, decrement, or clear. y_ovf is a
//           sticky flag that records any wrap.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   x              in   YW   value loaded into y by y_store_x
//   s_en           in   1    enables the s update this cycle
//   s_zero         in   1    s <- S_INIT (highest priority on the s path)
//   s_add          in   1    1 = add s_step modulo S_MOD, 0 = saturating subtract
//   s_step         in   2    step amount 0..3
//   y_en           in   1    enables the y update this cycle
//   y_store_x      in   1    y <- x, clears y_ovf (has priority over select)
//   y_select_next  in   2    0 hold, 1 inc, 2 dec, 3 clear
//   s              out  SW   step register
//   y              out  YW   value register
//   y_inc          out  1    s == S_MOD-1 (wrap-ahead flag for the FSM)
//   s_empty        out  1    s == 0
//   y_ovf          out  1    sticky wrap flag
// ---------------------------------------------------------------------------
module data_path #(
    parameter int SW     = 3,
    parameter int YW     = 8,
    parameter int S_MOD  = 3,
    parameter int S_INIT = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [YW-1:0] x,
    input  logic          s_en,
    input  logic          s_zero,
    input  logic          s_add,
    input  logic [1:0]    s_step,
    input  logic          y_en,
    input  logic          y_store_x,
    input  logic [1:0]    y_select_next,
    output logic [SW-1:0] s,
    output logic [YW-1:0] y,
    output logic          y_inc,
    output logic          s_empty,
    output logic          y_ovf
);

    // Add with a single conditional subtraction of the modulus. The sum is
    // kept one bit wider than s so a carry out of s is still compared.
    function automatic logic [SW-1:0] mod_add(input logic [SW-1:0] cur,
                                              input logic [1:0]    step);
        logic [SW:0] sum;
        sum = (SW+1)'(cur) + (SW+1)'(step);
        if (sum >= (SW+1)'(S_MOD))
            return SW'(sum - (SW+1)'(S_MOD));
        else
            return SW'(sum);
    endfunction

    // Subtract that clamps at zero instead of wrapping. The compare is done
    // two bits wider than s so it also holds when SW is smaller than the step.
    function automatic logic [SW-1:0] sat_sub(input logic [SW-1:0] cur,
                                              input logic [1:0]    step);
        if ((SW+2)'(cur) < (SW+2)'(step))
            return '0;
        else
            return cur - SW'(step);
    endfunction

    logic [SW-1:0] s_q, s_d;
    logic [YW-1:0] y_q, y_d;
    logic          y_ovf_q, y_ovf_d;

    always_comb begin
        s_d = s_q;
        if (s_en) begin
            if (s_zero)
                s_d = SW'(S_INIT);
            else if (s_add)
                s_d = mod_add(s_q, s_step);
            else
                s_d = sat_sub(s_q, s_step);
        end
    end

    always_comb begin
        y_d     = y_q;
        y_ovf_d = y_ovf_q;
        if (y_en) begin
            if (y_store_x) begin
                y_d     = x;
                y_ovf_d = 1'b0;
            end else begin
                case (y_select_next)
                    2'd1: begin
                        y_d = y_q + 1'b1;
                        if (&y_q)
                            y_ovf_d = 1'b1;
                    end
                    2'd2: begin
                        y_d = y_q - 1'b1;
                        if (y_q == '0)
                            y_ovf_d = 1'b1;
                    end
                    2'd3:    y_d = '0;
                    default: y_d = y_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            y_q     <= '0;
            y_ovf_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            y_q     <= y_d;
            y_ovf_q <= y_ovf_d;
        end
    end

    // Flags look only at the registered s so the FSM sees the pre-edge value.
    assign s       = s_q;
    assign y       = y_q;
    assign y_ovf   = y_ovf_q;
    assign y_inc   = (s_q == SW'(S_MOD - 1));
    assign s_empty = (s_q == '0);

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

    localparam int SW     = 3;
    localparam int YW     = 8;
    localparam int S_MOD  = 3;
    localparam int S_INIT = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [YW-1:0] x = '0;
    logic          s_en = 1'b0, s_zero = 1'b0, s_add = 1'b0;
    logic [1:0]    s_step = '0;
    logic          y_en = 1'b0, y_store_x = 1'b0;
    logic [1:0]    y_select_next = '0;
    logic [SW-1:0] s;
    logic [YW-1:0] y;
    logic          y_inc, s_empty, y_ovf;

    int errors = 0;
    int checks = 0;

    data_path #(.SW(SW), .YW(YW), .S_MOD(S_MOD), .S_INIT(S_INIT)) dut (
        .clk(clk), .rst(rst), .x(x),
        .s_en(s_en), .s_zero(s_zero), .s_add(s_add), .s_step(s_step),
        .y_en(y_en), .y_store_x(y_store_x), .y_select_next(y_select_next),
        .s(s), .y(y), .y_inc(y_inc), .s_empty(s_empty), .y_ovf(y_ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle past it before anyone samples.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_en = 0; s_zero = 0; s_add = 0; s_step = 0;
        y_en = 0; y_store_x = 0; y_select_next = 0; x = '0;
    endtask

    // Short asynchronous reset pulse issued between edges.
    task automatic pulse_reset();
        rst = 1; #1; rst = 0;
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1;
        #2;
        checks++; if (s !== 3'd0)    begin errors++; $display("FAIL reset_s: got %0d want 0", s); end
        checks++; if (y !== 8'd0)    begin errors++; $display("FAIL reset_y: got %0d want 0", y); end
        checks++; if (y_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", y_ovf); end
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", s_empty); end
        checks++; if (y_inc !== 1'b0) begin errors++; $display("FAIL reset_yinc: got %0b want 0", y_inc); end
        s_en = 1; s_zero = 1; y_en = 1; y_store_x = 1; x = 8'h77;
        tick();
        checks++; if (s !== 3'd0 || y !== 8'd0) begin errors++; $display("FAIL reset_dominates: got s=%0d y=%0h want s=0 y=0", s, y); end
        rst = 0;
        idle();
    endtask

    task automatic test_countdown();
        int exp_s[4] = '{4, 2, 0, 0};
        pulse_reset();
        idle(); s_en = 1; s_zero = 1;
        tick();
        checks++; if (s !== 3'd6) begin errors++; $display("FAIL preset_s: got %0d want 6", s); end
        s_zero = 0; s_add = 0; s_step = 2;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (s !== SW'(exp_s[i])) begin errors++; $display("FAIL countdown_s[%0d]: got %0d want %0d", i, s, exp_s[i]); end
            checks++; if (s_empty !== (i >= 2)) begin errors++; $display("FAIL countdown_empty[%0d]: got %0b want %0b", i, s_empty, (i >= 2)); end
        end
        idle();
    endtask

    task automatic test_count_wrap();
        int exp_s[4] = '{1, 2, 0, 1};
        pulse_reset();
        idle();
        checks++; if (y_inc !== 1'b0) begin errors++; $display("FAIL wrap_yinc_init: got %0b want 0", y_inc); end
        s_en = 1; s_add = 1; s_step = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (s !== SW'(exp_s[i])) begin errors++; $display("FAIL wrap_s[%0d]: got %0d want %0d", i, s, exp_s[i]); end
            checks++; if (y_inc !== (exp_s[i] == 2)) begin errors++; $display("FAIL wrap_yinc[%0d]: got %0b want %0b", i, y_inc, (exp_s[i] == 2)); end
        end
        s_zero = 1;
        tick();
        checks++; if (s !== 3'd6 || y_inc !== 1'b0) begin errors++; $display("FAIL wrap_preset: got s=%0d yinc=%0b want s=6 yinc=0", s, y_inc); end
        s_zero = 0;
        tick();
        checks++; if (s !== 3'd4) begin errors++; $display("FAIL wrap_from6: got %0d want 4", s); end
        idle();
    endtask

    task automatic test_y_ops();
        pulse_reset();
        idle(); y_en = 1; y_store_x = 1; x = 8'h5A;
        tick();
        checks++; if (y !== 8'h5A || y_ovf !== 1'b0) begin errors++; $display("FAIL y_store: got y=%0h ovf=%0b want y=5a ovf=0", y, y_ovf); end
        x = 8'hFF;
        tick();
        y_store_x = 0; y_select_next = 1;
        tick();
        checks++; if (y !== 8'h00 || y_ovf !== 1'b1) begin errors++; $display("FAIL y_inc_wrap: got y=%0h ovf=%0b want y=0 ovf=1", y, y_ovf); end
        y_select_next = 3;
        tick();
        checks++; if (y !== 8'h00 || y_ovf !== 1'b1) begin errors++; $display("FAIL y_clear: got y=%0h ovf=%0b want y=0 ovf=1", y, y_ovf); end
        y_store_x = 1; x = 8'h00;
        tick();
        checks++; if (y_ovf !== 1'b0) begin errors++; $display("FAIL y_store_clr_ovf: got %0b want 0", y_ovf); end
        y_store_x = 0; y_select_next = 2;
        tick();
        checks++; if (y !== 8'hFF || y_ovf !== 1'b1) begin errors++; $display("FAIL y_dec_wrap: got y=%0h ovf=%0b want y=ff ovf=1", y, y_ovf); end
        y_select_next = 0;
        tick();
        checks++; if (y !== 8'hFF) begin errors++; $display("FAIL y_hold: got %0h want ff", y); end
        idle();
    endtask

    task automatic test_saturation_hold();
        pulse_reset();
        idle(); s_en = 1; s_zero = 1;
        tick();
        s_zero = 0; s_add = 0; s_step = 2;
        tick(); tick();
        checks++; if (s !== 3'd2) begin errors++; $display("FAIL sat_setup: got %0d want 2", s); end
        s_step = 3;
        tick();
        checks++; if (s !== 3'd0) begin errors++; $display("FAIL sat_sub: got %0d want 0", s); end
        s_en = 0; s_zero = 1;
        tick();
        checks++; if (s !== 3'd0) begin errors++; $display("FAIL s_hold: got %0d want 0", s); end
        idle(); y_en = 1; y_store_x = 1; x = 8'h33;
        tick();
        y_en = 0; x = 8'h44;
        tick();
        checks++; if (y !== 8'h33) begin errors++; $display("FAIL y_hold_en: got %0h want 33", y); end
        idle();
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        idle(); s_en = 1; s_add = 1; s_step = 1; y_en = 1; y_store_x = 1; x = 8'h04;
        tick();
        y_en = 0;
        tick();
        checks++; if (s !== 3'd2 || y !== 8'h04) begin errors++; $display("FAIL simul_setup: got s=%0d y=%0h want s=2 y=4", s, y); end
        y_en = 1; y_store_x = 0; y_select_next = 1;
        tick();
        checks++; if (s !== 3'd0 || y !== 8'h05) begin errors++; $display("FAIL simul: got s=%0d y=%0h want s=0 y=5", s, y); end
        idle();
    endtask

    task automatic test_async_reset_mid();
        pulse_reset();
        idle(); s_en = 1; s_zero = 1; y_en = 1; y_store_x = 1; x = 8'h09;
        tick();
        s_zero = 0; s_add = 0; s_step = 1; y_en = 0;
        tick();
        checks++; if (s !== 3'd5 || y !== 8'h09) begin errors++; $display("FAIL arst_setup: got s=%0d y=%0h want s=5 y=9", s, y); end
        s_zero = 1; y_en = 1; y_store_x = 0; y_select_next = 1;
        #2 rst = 1;
        #1;
        checks++; if (s !== 3'd0 || y !== 8'h00 || y_ovf !== 1'b0 || s_empty !== 1'b1) begin
            errors++; $display("FAIL arst_mid: got s=%0d y=%0h ovf=%0b empty=%0b want 0 0 0 1", s, y, y_ovf, s_empty); end
        #1 rst = 0;
        tick();
        checks++; if (s !== 3'd6 || y !== 8'h01) begin errors++; $display("FAIL arst_release: got s=%0d y=%0h want s=6 y=1", s, y); end
        idle();
    endtask

    // Random sequences checked against a plain-arithmetic model of the rules.
    task automatic test_random();
        int ms, my, mo, t;
        pulse_reset();
        idle();
        ms = 0; my = 0; mo = 0;
        for (int i = 0; i < 400; i++) begin
            s_en = 1'($urandom_range(0, 3) != 0);
            s_zero = 1'($urandom_range(0, 7) == 0);
            s_add = 1'($urandom);
            s_step = 2'($urandom);
            y_en = 1'($urandom_range(0, 3) != 0);
            y_store_x = 1'($urandom_range(0, 9) == 0);
            y_select_next = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            x = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                #2 rst = 1;
                ms = 0; my = 0; mo = 0;
                #1 rst = 0;
            end
            @(posedge clk);
            if (s_en) begin
                if (s_zero) ms = S_INIT;
                else if (s_add) begin
                    t = ms + int'(s_step);
                    if (t >= S_MOD) t = t - S_MOD;
                    ms = t % (1 << SW);
                end else begin
                    t = ms - int'(s_step);
                    ms = (t < 0) ? 0 : t;
                end
            end
            if (y_en) begin
                if (y_store_x) begin my = int'(x); mo = 0; end
                else if (y_select_next == 1) begin if (my == 255) mo = 1; my = (my + 1) % 256; end
                else if (y_select_next == 2) begin if (my == 0) mo = 1; my = (my + 255) % 256; end
                else if (y_select_next == 3) my = 0;
            end
            #1;
            checks++; if (int'(s) !== ms || int'(y) !== my || int'(y_ovf) !== mo ||
                          y_inc !== (ms == S_MOD - 1) || s_empty !== (ms == 0)) begin
                errors++;
                $display("FAIL random[%0d]: got s=%0d y=%0h ovf=%0b yinc=%0b empty=%0b want s=%0d y=%0h ovf=%0d yinc=%0b empty=%0b",
                         i, s, y, y_ovf, y_inc, s_empty, ms, my, mo, (ms == S_MOD - 1), (ms == 0));
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_count_wrap();
        test_y_ops();
        test_saturation_hold();
        test_simultaneous();
        test_async_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
